// File: rtl/cond_code_unit.sv
// cond_code_unit: execute-stage condition-code register, branch/cmov
// condition evaluation, and the execute->memory boundary register.
// Optional feature macro: CC_BYPASS_EN. When defined, the condition is
// evaluated on the incoming ALU flags whenever they are being written in
// the same cycle, so a fused compare-and-branch sees the new flags.
module cond_code_unit #(
  parameter int BIT_WID = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         cc_in,
  input  logic               set_cc,
  input  logic               exc_block,
  input  logic [3:0]         ifun,
  input  logic               is_cond,
  input  logic [BIT_WID-1:0] valE_in,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               bubble,
  output logic [3:0]         cc_q,
  output logic               m_cnd,
  output logic [BIT_WID-1:0] m_valE,
  output logic               m_valid,
  output logic               m_bad_cond
);

  // Flag positions inside the CC vector
  localparam int ZF = 0;
  localparam int SF = 1;
  localparam int OF = 2;
  localparam int CF = 3;

  // Returns {bad, cnd} for a selector applied to a flag set.
  function automatic logic [1:0] eval_cond(input logic [3:0] cc,
                                           input logic [3:0] fn);
    logic z, s, o, c, lt;
    logic [1:0] r;
    z  = cc[ZF];
    s  = cc[SF];
    o  = cc[OF];
    c  = cc[CF];
    lt = s ^ o;
    r  = 2'b00;
    case (fn)
      4'd0:    r = 2'b01;
      4'd1:    r = {1'b0, lt | z};
      4'd2:    r = {1'b0, lt};
      4'd3:    r = {1'b0, z};
      4'd4:    r = {1'b0, ~z};
      4'd5:    r = {1'b0, ~lt};
      4'd6:    r = {1'b0, ~lt & ~z};
      4'd7:    r = {1'b0, c};
      4'd8:    r = {1'b0, c | z};
      4'd9:    r = {1'b0, ~c & ~z};
      4'd10:   r = {1'b0, ~c};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  logic       cc_upd;
  logic       cc_we;
  logic [3:0] cc_eval;
  logic       cnd;
  logic       bad;

  // A live, unblocked flag-setting instruction; stall additionally gates the write.
  assign cc_upd = set_cc & in_valid & ~exc_block;
  assign cc_we  = cc_upd & ~stall;

  // Select the flag set the condition is evaluated against.
  always_comb begin
`ifdef CC_BYPASS_EN
    cc_eval = cc_upd ? cc_in : cc_q;
`else
    cc_eval = cc_q;
`endif
  end

  // Condition result; non-conditional instructions never report a condition.
  always_comb begin
    cnd = 1'b0;
    bad = 1'b0;
    if (is_cond) begin
      {bad, cnd} = eval_cond(cc_eval, ifun);
    end
  end

  // Architectural CC register; reset state has only ZF set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= 4'b0001;
    end else if (cc_we) begin
      cc_q <= cc_in;
    end
  end

  // Execute->memory boundary: stall holds, bubble inserts a NOP, else load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_cnd      <= 1'b0;
      m_bad_cond <= 1'b0;
      m_valE     <= '0;
    end else if (stall) begin
      m_valid    <= m_valid;
      m_cnd      <= m_cnd;
      m_bad_cond <= m_bad_cond;
      m_valE     <= m_valE;
    end else if (bubble) begin
      m_valid    <= 1'b0;
      m_cnd      <= 1'b0;
      m_bad_cond <= 1'b0;
      m_valE     <= '0;
    end else begin
      m_valid    <= in_valid;
      m_cnd      <= cnd & in_valid;
      m_bad_cond <= bad & in_valid;
      m_valE     <= valE_in;
    end
  end

endmodule

// File: tb/tb_cond_code_unit.sv
// Directed testbench for cond_code_unit with hand-computed expectations.
// Honors CC_BYPASS_EN to pick the expected fused compare-and-branch result.
module tb_cond_code_unit;

  localparam int BIT_WID = 64;

  logic               clk;
  logic               rst;
  logic [3:0]         cc_in;
  logic               set_cc;
  logic               exc_block;
  logic [3:0]         ifun;
  logic               is_cond;
  logic [BIT_WID-1:0] valE_in;
  logic               in_valid;
  logic               stall;
  logic               bubble;
  logic [3:0]         cc_q;
  logic               m_cnd;
  logic [BIT_WID-1:0] m_valE;
  logic               m_valid;
  logic               m_bad_cond;

  int total = 0;
  int bad   = 0;

  cond_code_unit #(.BIT_WID(BIT_WID)) dut (
    .clk        (clk),
    .rst        (rst),
    .cc_in      (cc_in),
    .set_cc     (set_cc),
    .exc_block  (exc_block),
    .ifun       (ifun),
    .is_cond    (is_cond),
    .valE_in    (valE_in),
    .in_valid   (in_valid),
    .stall      (stall),
    .bubble     (bubble),
    .cc_q       (cc_q),
    .m_cnd      (m_cnd),
    .m_valE     (m_valE),
    .m_valid    (m_valid),
    .m_bad_cond (m_bad_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_u [4];
    logic exp_byp;
    exp_u[0] = 1; exp_u[1] = 1; exp_u[2] = 0; exp_u[3] = 0;

    rst = 1'b1; cc_in = '0; set_cc = 0; exc_block = 0; ifun = '0; is_cond = 0;
    valE_in = '0; in_valid = 0; stall = 0; bubble = 0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_cc", cc_q, 4'b0001);
    chk("rst_valid", m_valid, 0);

    // Load cc 1110 and a live always-true condition, then reset mid-cycle
    cc_in = 4'b1110; set_cc = 1; in_valid = 1; is_cond = 1; ifun = 4'd0; valE_in = 64'hABCD;
    cyc();
    chk("pre_cc", cc_q, 4'b1110);
    chk("pre_cnd", m_cnd, 1);
    chk("pre_valE", m_valE, 64'hABCD);
    set_cc = 0; is_cond = 0; in_valid = 0;
    #3 rst = 1'b1;
    #1;
    chk("async_cc", cc_q, 4'b0001);
    chk("async_cnd", m_cnd, 0);
    chk("async_valE", m_valE, 0);
    chk("async_valid", m_valid, 0);
    chk("async_bad", m_bad_cond, 0);
    rst = 1'b0;
    cyc();

    // CC write then signed less / greater-equal
    cc_in = 4'b0010; set_cc = 1; in_valid = 1; is_cond = 0;
    cyc();
    chk("ccw_sf", cc_q, 4'b0010);
    set_cc = 0; is_cond = 1; ifun = 4'd2;
    cyc();
    chk("l_true", m_cnd, 1);
    ifun = 4'd5;
    cyc();
    chk("ge_false", m_cnd, 0);

    // Exception suppression
    cc_in = 4'b0001; set_cc = 1; is_cond = 0;
    cyc();
    cc_in = 4'b0000; exc_block = 1;
    cyc();
    chk("exc_hold", cc_q, 4'b0001);
    exc_block = 0; set_cc = 0; is_cond = 1; ifun = 4'd3;
    cyc();
    chk("e_true", m_cnd, 1);

    // Unsigned conditions with CF set
    cc_in = 4'b1000; set_cc = 1; is_cond = 0;
    cyc();
    chk("ccw_cf", cc_q, 4'b1000);
    set_cc = 0; is_cond = 1;
    for (int i = 0; i < 4; i++) begin
      ifun = 4'(7 + i);
      cyc();
      chk($sformatf("uns_%0d", 7 + i), m_cnd, exp_u[i]);
    end
    cc_in = 4'b0000; set_cc = 1; is_cond = 0;
    cyc();
    set_cc = 0; is_cond = 1; ifun = 4'd9;
    cyc();
    chk("a_true", m_cnd, 1);
    ifun = 4'd1;
    cyc();
    chk("le_false", m_cnd, 0);
    ifun = 4'd6;
    cyc();
    chk("g_true", m_cnd, 1);

    // Non-conditional and invalid instructions never flag
    is_cond = 0; ifun = 4'd12;
    cyc();
    chk("nocond_bad", m_bad_cond, 0);
    chk("nocond_cnd", m_cnd, 0);
    is_cond = 1; in_valid = 0; ifun = 4'd0;
    cyc();
    chk("inv_cnd", m_cnd, 0);
    chk("inv_valid", m_valid, 0);

    // Stall and bubble
    is_cond = 0; in_valid = 1; valE_in = 64'h55;
    cyc();
    chk("ld_valE", m_valE, 64'h55);
    chk("ld_valid", m_valid, 1);
    valE_in = 64'h1234; stall = 1; set_cc = 1; cc_in = 4'b1111;
    cyc();
    chk("stall_valE", m_valE, 64'h55);
    chk("stall_cc", cc_q, 4'b0000);
    bubble = 1;
    cyc();
    chk("sb_valE", m_valE, 64'h55);
    chk("sb_valid", m_valid, 1);
    chk("sb_cc", cc_q, 4'b0000);
    stall = 0; cc_in = 4'b0100;
    cyc();
    chk("bub_valid", m_valid, 0);
    chk("bub_valE", m_valE, 0);
    chk("bub_ccw", cc_q, 4'b0100);

    // Undefined selector
    bubble = 0; set_cc = 0; is_cond = 1; ifun = 4'd12; in_valid = 1;
    cyc();
    chk("undef_cnd", m_cnd, 0);
    chk("undef_bad", m_bad_cond, 1);
    in_valid = 0;
    cyc();
    chk("undef_inv_bad", m_bad_cond, 0);

    // Same-cycle flag write and equal test
    in_valid = 1; is_cond = 0; cc_in = 4'b0000; set_cc = 1;
    cyc();
    cc_in = 4'b0001; is_cond = 1; ifun = 4'd3;
    cyc();
`ifdef CC_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    chk("fused_cnd", m_cnd, exp_byp);
    chk("fused_cc", cc_q, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
